// File: rtl/p2s_tx_sched.sv
// Transmit scheduler for the 4-lane P2S link: round-robin A/B frame capture,
// serializer valid/enable/bit-counter sequencing and inter-frame idle gap.
module p2s_tx_sched #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
  input  logic        IN_CLK_2MHz,
  input  logic        IN_RESET_TX,
  input  logic        IN_REQ_A,
  input  logic [31:0] IN_DATA_A,
  output logic        OUT_ACK_A,
  input  logic        IN_REQ_B,
  input  logic [31:0] IN_DATA_B,
  output logic        OUT_ACK_B,
  output logic [7:0]  OUT_LANE3,
  output logic [7:0]  OUT_LANE2,
  output logic [7:0]  OUT_LANE1,
  output logic [7:0]  OUT_LANE0,
  output logic        OUT_VALID_TX,
  output logic        OUT_ENB_TX,
  output logic [2:0]  OUT_CTR_TX,
  output logic        OUT_GRANT,
  output logic        OUT_BUSY,
  output logic [7:0]  OUT_FRAME_CNT
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [3:0]  GapLoad   = 4'(GAP_CYCLES);
  localparam logic [31:0] IdleLanes = {4{IDLE_BYTE}};

  logic [1:0]  state_q, state_d;
  logic [2:0]  ctr_q, ctr_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] lanes_q, lanes_d;
  logic        valid_q, valid_d;
  logic        enb_q, enb_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        grant_q, grant_d;
  logic        prio_b_q, prio_b_d;  // 1: B wins a tie
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic any_req;
  logic win_b;

  assign any_req = IN_REQ_A | IN_REQ_B;
  assign win_b   = IN_REQ_B & (~IN_REQ_A | prio_b_q);

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    gap_d       = gap_q;
    lanes_d     = lanes_q;
    valid_d     = valid_q;
    enb_d       = enb_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    grant_d     = grant_q;
    prio_b_d    = prio_b_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        enb_d   = 1'b0;
        ctr_d   = 3'd0;
        lanes_d = IdleLanes;
        if (any_req) begin
          state_d  = StSend;
          lanes_d  = win_b ? IN_DATA_B : IN_DATA_A;
          ack_a_d  = ~win_b;
          ack_b_d  = win_b;
          grant_d  = win_b;
          prio_b_d = ~win_b;
          valid_d  = 1'b1;
          enb_d    = 1'b1;
        end
      end

      StSend: begin
        if (ctr_q == 3'd7) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          ctr_d       = 3'd0;
          if (GAP_CYCLES != 0) begin
            state_d = StGap;
            gap_d   = GapLoad;
            valid_d = 1'b0;
            enb_d   = 1'b1;
            lanes_d = IdleLanes;
          end else if (any_req) begin
            // Back-to-back: recapture without passing through IDLE.
            lanes_d  = win_b ? IN_DATA_B : IN_DATA_A;
            ack_a_d  = ~win_b;
            ack_b_d  = win_b;
            grant_d  = win_b;
            prio_b_d = ~win_b;
            valid_d  = 1'b1;
            enb_d    = 1'b1;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            enb_d   = 1'b0;
            lanes_d = IdleLanes;
          end
        end else begin
          ctr_d = ctr_q + 3'd1;
        end
      end

      StGap: begin
        if (gap_q <= 4'd1) begin
          state_d = StIdle;
          gap_d   = 4'd0;
          enb_d   = 1'b0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        enb_d   = 1'b0;
        ctr_d   = 3'd0;
        gap_d   = 4'd0;
        lanes_d = IdleLanes;
      end
    endcase
  end

  always_ff @(posedge IN_CLK_2MHz) begin
    if (!IN_RESET_TX) begin
      state_q     <= StIdle;
      ctr_q       <= 3'd0;
      gap_q       <= 4'd0;
      lanes_q     <= IdleLanes;
      valid_q     <= 1'b0;
      enb_q       <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      grant_q     <= 1'b0;
      prio_b_q    <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      gap_q       <= gap_d;
      lanes_q     <= lanes_d;
      valid_q     <= valid_d;
      enb_q       <= enb_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      grant_q     <= grant_d;
      prio_b_q    <= prio_b_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign OUT_ACK_A     = ack_a_q;
  assign OUT_ACK_B     = ack_b_q;
  assign OUT_LANE3     = lanes_q[31:24];
  assign OUT_LANE2     = lanes_q[23:16];
  assign OUT_LANE1     = lanes_q[15:8];
  assign OUT_LANE0     = lanes_q[7:0];
  assign OUT_VALID_TX  = valid_q;
  assign OUT_ENB_TX    = enb_q;
  assign OUT_CTR_TX    = ctr_q;
  assign OUT_GRANT     = grant_q;
  assign OUT_BUSY      = (state_q != StIdle);
  assign OUT_FRAME_CNT = frame_cnt_q;

endmodule
